sm_trace_buf: RTL
=================

# sm_trace_buf

Synthesizable instruction-trace capture buffer for the sm_top CPU; the hardware successor to the simulation-only PC/instruction printout and cycle timeout. It records one entry per enabled CPU cycle, holding PC, instruction word and cycle stamp, into a circular buffer of parametrised depth. Capture stops on a PC-match trigger after a programmable post-trigger window, or on a cycle-limit timeout. Entries are read back oldest-first through an indexed read port, in the same style as the regAddr/regData debug port.

## Interface
- DEPTH, 16: entry count; power of two, ≥4; AW = $clog2(DEPTH)
- POST_TRIG, 4: entries captured after the trigger entry; 0..DEPTH-1
- CYC_W, 16: width of the cycle stamp and timeout limit
- clk  in  1  CPU clock
- rst_n  in  1  reset; one clock; reset is synchronous and active-low
- en  in  1  capture qualifier (CPU clock enable); one entry per high cycle while capturing
- pc  in  32  word PC of the current instruction
- instr  in  32  current instruction word
- arm  in  1  single-cycle pulse; clears the buffer and starts capture
- trigEn  in  1  enables the PC-match trigger
- trigPc  in  32  trigger PC
- timeoutLimit  in  CYC_W  capture limit; 0 disables the timeout
- rdIdx  in  AW  logical read index; 0 = oldest valid entry
- rdSel  in  2  0 pc, 1 instr, 2 cycle stamp (zero-extended), 3 status
- rdData  out  32  registered read data
- state  out  2  0 IDLE, 1 ARMED, 2 POST, 3 DONE
- count  out  AW+1  valid entries, saturating at DEPTH
- wrapped  out  1  at least one entry has been overwritten since arm
- timeout  out  1  capture ended by the timeout

## Operation
- States:
  - IDLE: no capture. arm moves to ARMED.
  - ARMED: capture on en. A trigger capture moves to POST, or to DONE if POST_TRIG=0.
  - POST: capture on en; decrement the post counter. The capture that brings it to 0 moves to DONE.
  - DONE: frozen; en is ignored. arm moves to ARMED.
- arm, in any state: write pointer, count, cycle counter, wrapped and timeout are cleared; next state is ARMED. Entry memory is not cleared.
- Capture: write {pc, instr, cyc} at the write pointer, advance the pointer modulo DEPTH, and increment count up to DEPTH.
  - A write while count==DEPTH sets wrapped.
  - cyc starts at 0 after arm, increments once per capture, and wraps modulo 2^CYC_W.
- Trigger: trigEn && pc==trigPc on a capture cycle in ARMED. The matching entry is stored. Later matches in POST are ignored.
- Timeout: timeoutLimit≠0 and the capture has cyc==timeoutLimit-1. That capture is stored, then timeout=1 and the state moves to DONE.
- Read mapping: physical index = wrapped ? (wp+rdIdx) mod DEPTH : rdIdx.
  - Indices ≥ count return 0 for sel 0–2.
  - Status word: [1:0] state, [2] wrapped, [3] timeout, [4+AW:4] count, upper bits 0.
- Simultaneous events:
  - arm together with en: arm wins; no capture.
  - Trigger and timeout on the same capture: timeout wins (DONE, timeout=1).
  - Trigger together with wrap: both take effect.
- Reset mid-capture: IDLE; all flags and counters 0. Memory contents are unspecified.

## Timing
- Reset values: state=0, count=0, wrapped=0, timeout=0, rdData=0.
- Capture writes on the rising clk edge where en is high; count, flags and state update on that same edge.
- rdData has 1-cycle latency from rdIdx/rdSel. Reads may occur in any state. A same-cycle write to the addressed entry returns the old data.
- arm takes effect on the edge it is sampled; the first capture is possible on the following edge.
- No backpressure; en is never stalled.

## Structure
- Package/header sm_trace.vh:
  - state encodings TR_IDLE/TR_ARMED/TR_POST/TR_DONE
  - rdSel codes
  - status field offsets
- One sub-module: sm_trace_ram, a DEPTH×(64+CYC_W) simple dual-port RAM with synchronous write and registered read, inferable as block RAM.
- Top logic: FSM, write pointer, count, cycle, post and timeout counters, and the read-index mapping and output mux.

## Test plan
All scenarios use DEPTH=8, POST_TRIG=2, CYC_W=16, en=1 unless noted.
1. Reset held 4 cycles, then released with no arm → state=0, count=0, rdData=0. en toggling changes nothing.
2. arm; 5 captures pc=0..4; trigEn=0, timeoutLimit=0 → state=1, count=5, wrapped=0. rdIdx 0/4 sel 0 → 0/4; sel 2 → 0/4. rdIdx 6 → 0.
3. arm; 11 captures pc=0..10 → count=8, wrapped=1. rdIdx0 → pc 3, cyc 3; rdIdx7 → pc 10.
4. arm; trigEn=1, trigPc=5; pc 0,1,2,… → captures 0..7, state=3 after pc 7, timeout=0. Further en leaves count=8 and rdIdx7 → 7.
5. arm; timeoutLimit=4; pc 20..30 → DONE after 4 captures, timeout=1, count=4, sel 2 → 0..3. A second test sets trigPc equal to the 4th pc → timeout=1.
6. In ARMED, assert arm together with en → count=0, no capture. In POST, assert rst_n=0 for 1 cycle → state=0, all flags 0, rdData=0.

Source files
------------

// File: rtl/sm_trace_pkg.sv
// sm_trace_pkg: shared definitions for the sm_trace_buf instruction-trace buffer.
//   trState_t - capture FSM state encoding (also the value seen on the state port)
//   rdSel_t   - read-port field selector codes
//   ST_*      - bit offsets of the fields inside the status read word
package sm_trace_pkg;

    typedef enum logic [1:0] {
        TR_IDLE  = 2'd0,
        TR_ARMED = 2'd1,
        TR_POST  = 2'd2,
        TR_DONE  = 2'd3
    } trState_t;

    typedef enum logic [1:0] {
        RD_PC     = 2'd0,
        RD_INSTR  = 2'd1,
        RD_CYC    = 2'd2,
        RD_STATUS = 2'd3
    } rdSel_t;

    localparam int unsigned ST_STATE_LSB = 0;
    localparam int unsigned ST_WRAP_BIT  = 2;
    localparam int unsigned ST_TMO_BIT   = 3;
    localparam int unsigned ST_COUNT_LSB = 4;

endpackage

// File: rtl/sm_trace_ram.sv
// sm_trace_ram: DEPTH x WIDTH simple dual-port RAM, synchronous write and
// registered read-before-write, written to infer block RAM.
//   clk    - clock
//   we     - write enable
//   wrAddr - write address
//   wrData - write data
//   rdAddr - read address
//   rdData - registered read data (old contents on a same-cycle write)
module sm_trace_ram #(
    parameter  int unsigned DEPTH = 16,
    parameter  int unsigned WIDTH = 80,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    wrAddr,
    input  logic [WIDTH-1:0] wrData,
    input  logic [AW-1:0]    rdAddr,
    output logic [WIDTH-1:0] rdData
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wrAddr] <= wrData;
        end
        rdData <= mem[rdAddr];
    end

endmodule

// File: rtl/sm_trace_buf.sv
// sm_trace_buf: instruction-trace capture buffer for the sm_top CPU.
// Records {pc, instr, cycle stamp} per enabled cycle into a circular buffer;
// capture stops after a post-trigger window following a PC match, or on a
// cycle-limit timeout. Entries are read back oldest-first by logical index.
//   clk, rst_n   - clock, synchronous active-low reset
//   en           - capture qualifier (CPU clock enable)
//   pc, instr    - current PC and instruction word
//   arm          - pulse: clear buffer bookkeeping and start capture
//   trigEn       - enable PC-match trigger
//   trigPc       - trigger PC
//   timeoutLimit - capture limit in entries, 0 disables
//   rdIdx, rdSel - logical read index (0 = oldest) and field select
//   rdData       - read data, 1-cycle latency
//   state        - FSM state
//   count        - valid entries, saturating at DEPTH
//   wrapped      - an entry has been overwritten since arm
//   timeout      - capture ended by the timeout
module sm_trace_buf
    import sm_trace_pkg::*;
#(
    parameter  int unsigned DEPTH     = 16,
    parameter  int unsigned POST_TRIG = 4,
    parameter  int unsigned CYC_W     = 16,
    localparam int unsigned AW        = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [31:0]      pc,
    input  logic [31:0]      instr,
    input  logic             arm,
    input  logic             trigEn,
    input  logic [31:0]      trigPc,
    input  logic [CYC_W-1:0] timeoutLimit,
    input  logic [AW-1:0]    rdIdx,
    input  logic [1:0]       rdSel,
    output logic [31:0]      rdData,
    output logic [1:0]       state,
    output logic [AW:0]      count,
    output logic             wrapped,
    output logic             timeout
);

    localparam int unsigned EW   = 64 + CYC_W;
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    trState_t         stateQ, stateD;
    logic [AW-1:0]    wp;
    logic [AW:0]      cnt;
    logic [CYC_W-1:0] cyc;
    logic [AW-1:0]    postCnt;
    logic             wrapQ, tmoQ;

    logic             capture, trigHit, tmoHit, postLast;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stateQ <= TR_IDLE;
        end else begin
            stateQ <= stateD;
        end
    end

    // ---------------- FSM: next state ----------------
    // Timeout is tested ahead of the trigger so it wins on a shared capture.
    always_comb begin
        stateD = stateQ;
        if (arm) begin
            stateD = TR_ARMED;
        end else begin
            case (stateQ)
                TR_ARMED: begin
                    if (tmoHit) begin
                        stateD = TR_DONE;
                    end else if (trigHit) begin
                        stateD = (POST_TRIG == 0) ? TR_DONE : TR_POST;
                    end
                end
                TR_POST: begin
                    if (tmoHit || postLast) begin
                        stateD = TR_DONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ---------------- FSM: outputs / capture decode ----------------
    // arm suppresses capture on the cycle it is sampled.
    always_comb begin
        capture  = !arm && en && (stateQ == TR_ARMED || stateQ == TR_POST);
        tmoHit   = capture && (timeoutLimit != '0) &&
                   (cyc == timeoutLimit - CYC_W'(1));
        trigHit  = capture && (stateQ == TR_ARMED) && trigEn && (pc == trigPc);
        postLast = capture && (stateQ == TR_POST) && (postCnt == AW'(1));
    end

    // ---------------- Capture bookkeeping ----------------
    always_ff @(posedge clk) begin
        if (!rst_n || arm) begin
            wp      <= '0;
            cnt     <= '0;
            cyc     <= '0;
            postCnt <= '0;
            wrapQ   <= 1'b0;
            tmoQ    <= 1'b0;
        end else if (capture) begin
            wp  <= wp + AW'(1);
            cyc <= cyc + CYC_W'(1);
            if (cnt == FULL) begin
                wrapQ <= 1'b1;
            end else begin
                cnt <= cnt + (AW+1)'(1);
            end
            if (tmoHit) begin
                tmoQ <= 1'b1;
            end
            if (trigHit) begin
                postCnt <= AW'(POST_TRIG);
            end else if (stateQ == TR_POST) begin
                postCnt <= postCnt - AW'(1);
            end
        end
    end

    // ---------------- Entry storage ----------------
    logic [AW-1:0] rdPhys;
    logic [EW-1:0] ramQ;

    // Once wrapped, the oldest entry sits at the write pointer.
    assign rdPhys = wrapQ ? (wp + rdIdx) : rdIdx;

    sm_trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) uRam (
        .clk    (clk),
        .we     (capture),
        .wrAddr (wp),
        .wrData ({pc, instr, cyc}),
        .rdAddr (rdPhys),
        .rdData (ramQ)
    );

    // ---------------- Read port ----------------
    // Select, range check and status are registered alongside the RAM read so
    // all of rdData reflects the same sampling edge.
    rdSel_t      rdSelQ;
    logic        rdValidQ;
    logic [31:0] statusNow, statusQ;

    always_comb begin
        statusNow                          = '0;
        statusNow[ST_STATE_LSB +: 2]       = stateQ;
        statusNow[ST_WRAP_BIT]             = wrapQ;
        statusNow[ST_TMO_BIT]              = tmoQ;
        statusNow[ST_COUNT_LSB +: (AW+1)]  = cnt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdSelQ   <= RD_PC;
            rdValidQ <= 1'b0;
            statusQ  <= '0;
        end else begin
            rdSelQ   <= rdSel_t'(rdSel);
            rdValidQ <= ({1'b0, rdIdx} < cnt);
            statusQ  <= statusNow;
        end
    end

    always_comb begin
        rdData = '0;
        case (rdSelQ)
            RD_PC:     if (rdValidQ) rdData = ramQ[CYC_W+32 +: 32];
            RD_INSTR:  if (rdValidQ) rdData = ramQ[CYC_W +: 32];
            RD_CYC:    if (rdValidQ) rdData = 32'(ramQ[CYC_W-1:0]);
            RD_STATUS: rdData = statusQ;
            default:   rdData = '0;
        endcase
    end

    assign state   = stateQ;
    assign count   = cnt;
    assign wrapped = wrapQ;
    assign timeout = tmoQ;

endmodule
